// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - Memory op encodings, access-size constants and op decode helpers
package mem_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LB   = 4'd4,
    OP_LBU  = 4'd5,
    OP_SW   = 4'd8,
    OP_SH   = 4'd9,
    OP_SB   = 4'd10
  } mem_op_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Undefined codes fall through to byte size so they can never flag misalignment.
  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      OP_LW, OP_SW:         return SIZE_W;
      OP_LH, OP_LHU, OP_SH: return SIZE_H;
      default:              return SIZE_B;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// rtl/mem_byte_lane.sv - Byte-lane steering: store merge, load extract/extend, misalign detect
module mem_byte_lane
  import mem_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] old_word,
  output logic [3:0]  byte_en,
  output logic [31:0] merged_word,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [1:0]  size;
  logic [31:0] wr_rep;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    size       = op_size(op);
    misaligned = ((size == SIZE_W) && (addr_lo != 2'b00)) ||
                 ((size == SIZE_H) && addr_lo[0]);

    // Replicate the store data across lanes so the enables alone pick the target bytes.
    byte_en = 4'b0000;
    wr_rep  = store_data;
    if (is_store(op)) begin
      case (size)
        SIZE_B: begin
          byte_en = 4'b0001 << addr_lo;
          wr_rep  = {4{store_data[7:0]}};
        end
        SIZE_H: begin
          byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
          wr_rep  = {2{store_data[15:0]}};
        end
        default: byte_en = 4'b1111;
      endcase
    end

    for (int i = 0; i < 4; i++) begin
      merged_word[8*i +: 8] = byte_en[i] ? wr_rep[8*i +: 8] : old_word[8*i +: 8];
    end

    case (addr_lo)
      2'd0:    ld_byte = old_word[7:0];
      2'd1:    ld_byte = old_word[15:8];
      2'd2:    ld_byte = old_word[23:16];
      default: ld_byte = old_word[31:24];
    endcase
    ld_half = addr_lo[1] ? old_word[31:16] : old_word[15:0];

    case (op)
      OP_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  load_data = {24'h0, ld_byte};
      OP_LH:   load_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  load_data = {16'h0, ld_half};
      default: load_data = old_word;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit: data memory, load latency FSM, store trace
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 3072,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_rt_data,
  input  logic [31:0] req_fwd_data,
  input  logic        req_fwd_sel,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        exc,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS * 4);

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  logic [31:0] mem_q [DEPTH_WORDS];

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic [READ_LAT-1:0] vld_q, vld_d;
  logic [31:0] data_q [READ_LAT];
  logic [31:0] data_d [READ_LAT];
  logic        exc_q, exc_d;
  logic        trace_valid_q, trace_valid_d;
  logic [31:0] trace_pc_q, trace_pc_d;
  logic [31:0] trace_addr_q, trace_addr_d;
  logic [31:0] trace_data_q, trace_data_d;

  logic [31:0]      off, rd_word, st_data, merged_word, ld_ext;
  logic [IDX_W-1:0] widx;
  logic [3:0]       byte_en;
  logic             oor, misal, accept, fault, ld_go, st_go;

  assign off     = req_addr - ADDR_BASE;
  assign oor     = off >= MEM_BYTES;
  assign widx    = off[IDX_W+1:2];
  assign rd_word = oor ? 32'h0 : mem_q[widx];
  assign st_data = req_fwd_sel ? req_fwd_data : req_rt_data;

  assign accept = req_valid && req_ready_q;
  assign fault  = accept && (is_load(req_op) || is_store(req_op)) && (misal || oor);
  assign ld_go  = accept && is_load(req_op) && !fault;
  assign st_go  = accept && is_store(req_op) && !fault;

  mem_byte_lane u_lane (
    .op          (req_op),
    .addr_lo     (req_addr[1:0]),
    .store_data  (st_data),
    .old_word    (rd_word),
    .byte_en     (byte_en),
    .merged_word (merged_word),
    .load_data   (ld_ext),
    .misaligned  (misal)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ld_go && (READ_LAT > 1)) begin
          state_d = ST_WAIT;
          cnt_d   = 3'(READ_LAT - 1);
        end
      end
      default: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_d == 3'd0) state_d = ST_IDLE;
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);

    // Each stage only reloads when fresh data arrives, so the last stage holds resp_data.
    vld_d[0]  = ld_go;
    data_d[0] = ld_go ? ld_ext : data_q[0];
    for (int i = 1; i < READ_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = vld_q[i-1] ? data_q[i-1] : data_q[i];
    end

    exc_d         = fault;
    trace_valid_d = st_go;
    trace_pc_d    = st_go ? req_pc : trace_pc_q;
    trace_addr_d  = st_go ? {req_addr[31:2], 2'b00} : trace_addr_q;
    trace_data_d  = st_go ? merged_word : trace_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 3'd0;
      req_ready_q   <= 1'b1;
      vld_q         <= '0;
      for (int i = 0; i < READ_LAT; i++) data_q[i] <= 32'h0;
      exc_q         <= 1'b0;
      trace_valid_q <= 1'b0;
      trace_pc_q    <= 32'h0;
      trace_addr_q  <= 32'h0;
      trace_data_q  <= 32'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      vld_q         <= vld_d;
      for (int i = 0; i < READ_LAT; i++) data_q[i] <= data_d[i];
      exc_q         <= exc_d;
      trace_valid_q <= trace_valid_d;
      trace_pc_q    <= trace_pc_d;
      trace_addr_q  <= trace_addr_d;
      trace_data_q  <= trace_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'h0;
    end else if (st_go && (byte_en != 4'b0000)) begin
      mem_q[widx] <= merged_word;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = vld_q[READ_LAT-1];
  assign resp_data   = data_q[READ_LAT-1];
  assign exc         = exc_q;
  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_addr  = trace_addr_q;
  assign trace_data  = trace_data_q;

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Parametrised MEM-stage load/store unit for the pipelined MIPS core, sitting between the EX/MEM and MEM/WB pipeline registers. It owns a byte-addressable data memory with word, halfword and byte loads and stores, and sign/zero extension. It applies a configurable read latency with a ready/valid handshake that stalls the pipeline. It also flags misaligned or out-of-range accesses and emits a per-store trace record.

## Interface
Parameters:
- DEPTH_WORDS, 3072: data memory size in 32-bit words.
- ADDR_BASE, 32'h0000_0000: byte address of word 0.
- READ_LAT, 1: load latency in cycles; legal range 1..4.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  MEM-stage request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_op  in  4  memory op, encoded per mem_pkg.
- req_addr  in  32  byte address from ALU.
- req_rt_data  in  32  store data from register file.
- req_fwd_data  in  32  forwarded WB-stage data.
- req_fwd_sel  in  1  0 selects rt_data, 1 selects fwd_data as store source.
- req_pc  in  32  PC of the instruction, for the trace.
- resp_valid  out  1  load data valid; one-cycle pulse.
- resp_data  out  32  extended load data.
- exc  out  1  one-cycle pulse on a misaligned or out-of-range access.
- trace_valid, trace_pc[31:0], trace_addr[31:0], trace_data[31:0]  out  store trace; trace_addr is the word-aligned address, and trace_data is the full word after the write.

## Operation
- Ops (mem_pkg): NONE=0, LW=1, LH=2, LHU=3, LB=4, LBU=5, SW=8, SH=9, SB=10. All other codes behave as NONE.
- Offset: off = req_addr - ADDR_BASE. The access is out of range when off >= DEPTH_WORDS*4. Word index = off[31:2].
- Misaligned means: LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]=1.
- Faulting access: exc pulses in the cycle after acceptance. There is no memory write and no resp_valid, and no stall occurs.
- Store data source: store data = req_fwd_sel ? req_fwd_data : req_rt_data.
- Store byte lanes:
  - SB writes lane addr[1:0] with data[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with data[15:0], little-endian.
  - SW writes all four lanes.
- Load extraction:
  - LB/LBU select byte addr[1:0] and extend it.
  - LH/LHU select half addr[1] and extend it.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Stores complete at the acceptance edge. The trace fires in the next cycle with the merged word.
- Loads are blocking: only one load may be outstanding.
- FSM states:
  - IDLE: req_ready=1. An accepted load with READ_LAT>1 goes to WAIT and loads a counter with READ_LAT-1. With READ_LAT=1, the load is answered directly and the FSM stays in IDLE.
  - WAIT: req_ready=0. The counter decrements each cycle; at 0 the FSM returns to IDLE.
- Load data is sampled from the array at the acceptance edge. A pipeline of READ_LAT registers delivers it, so later writes cannot alter an in-flight load.

## Timing
- Reset values:
  - req_ready=1, resp_valid=0, resp_data=0, exc=0.
  - trace_valid=0 and all trace fields 0.
  - FSM in IDLE, counter 0.
  - Every memory word cleared to 0 in the reset cycle.
- Load accepted in cycle t:
  - resp_valid=1 in cycle t+READ_LAT only.
  - req_ready=0 in cycles t+1..t+READ_LAT-1.
  - req_ready=1 in cycle t+READ_LAT, allowing back-to-back issue.
- Store accepted in cycle t: data is visible to a load accepted in cycle t+1, and trace_valid=1 in cycle t+1.
- resp_data holds its last value when resp_valid=0.
- Reset asserted mid-load aborts the load: no resp_valid is issued and the FSM returns to IDLE.
- req_valid during WAIT is ignored. The upstream stage must hold the request until it is accepted.

## Structure
- mem_pkg holds the op encodings, the is_load/is_store/size helper functions, and the lane-size constants.
- Sub-module mem_byte_lane is purely combinational. It computes the write byte-enables and merged store word, the load extraction/extension, and the misalign flag.
- The top level holds the memory array, the FSM/counter, the READ_LAT pipeline and the trace registers.

## Test plan
- Reset, then SW 32'h8000_00F1 @0x10. Then LB, LBU, LH, LHU, LW @0x10:
  - LB → FFFF_FFF1, LBU → 0000_00F1.
  - LH → 0000_00F1, LHU → 0000_00F1.
  - LW → 8000_00F1.
- SB 0xAB @0x13 and SH 0x1234 @0x10 onto 0, then LW @0x10 → AB00_1234. The trace shows the word after each write: 0xAB000000, then 0xAB001234.
- READ_LAT=3, back-to-back LW @0x0 and LW @0x4:
  - req_ready low for 2 cycles after each acceptance.
  - resp_valid exactly 3 cycles after each acceptance.
  - Second acceptance in the first response cycle.
- LW @0x2, SH @0x1, and LW @DEPTH_WORDS*4: exc pulses each time, memory unchanged, no resp_valid.
- Store forwarding: SW with fwd_sel=1, fwd_data=DEAD_BEEF, rt_data=0, then LW → DEAD_BEEF.
- READ_LAT=4, reset asserted 2 cycles after a load: no resp_valid, req_ready=1, and LW of a previously written word → 0.
